// File: rtl/apb_spi_master.sv
// APB slave register block driving a mode-0, MSB-first, 8-bit SPI master.
// Build option: define APB_SPI_WAIT_STATE_EN to add one wait state to every APB access.
module apb_spi_master #(
    parameter logic [7:0]  CLKDIV_RST = 8'd3,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic [31:0] PADDR,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic        PREADY,
    output logic [31:0] PRDATA,
    output logic        PSLVERR,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        CS_N
);
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned BW  = 8;
    localparam int unsigned BCW = 3;

    localparam logic [AW-1:0] OFF_CTRL   = 32'h00;
    localparam logic [AW-1:0] OFF_CLKDIV = 32'h04;
    localparam logic [AW-1:0] OFF_TXDATA = 32'h08;
    localparam logic [AW-1:0] OFF_RXDATA = 32'h0C;
    localparam logic [AW-1:0] OFF_STATUS = 32'h10;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t          state, state_d;
    logic            en, en_d, cs, cs_d;
    logic [BW-1:0]   clkdiv, clkdiv_d;
    logic [BW-1:0]   cnt, cnt_d;
    logic [BW-1:0]   shreg, shreg_d;
    logic [BW-1:0]   rxdata, rxdata_d;
    logic [BCW-1:0]  bitcnt, bitcnt_d;
    logic            sclk, sclk_d, mosi, mosi_d;
    logic            rxv, rxv_d, ovr, ovr_d;

    logic [AW-1:0]   offset;
    logic            sel_ctrl, sel_div, sel_tx, sel_rx, sel_st, mapped;
    logic            busy, xfer, err_c, wr_ok, rd_ok, rd_rx, rd_st, abort;
    logic [DW-1:0]   rdata_c;
    logic            unused_pwdata;

    // APB handshake: zero-wait or single-wait build
`ifdef APB_SPI_WAIT_STATE_EN
    logic wait_done;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wait_done <= 1'b0;
        end else begin
            wait_done <= PSEL & PENABLE & ~wait_done;
        end
    end

    assign PREADY = wait_done;
`else
    assign PREADY = 1'b1;
`endif

    assign offset   = PADDR - BASE_ADDR;
    assign sel_ctrl = (offset == OFF_CTRL);
    assign sel_div  = (offset == OFF_CLKDIV);
    assign sel_tx   = (offset == OFF_TXDATA);
    assign sel_rx   = (offset == OFF_RXDATA);
    assign sel_st   = (offset == OFF_STATUS);
    assign mapped   = sel_ctrl | sel_div | sel_tx | sel_rx | sel_st;

    assign busy  = (state != IDLE);
    assign xfer  = PSEL & PENABLE & PREADY;
    assign err_c = ~mapped
                 | (PWRITE & (sel_rx | sel_st))
                 | (~PWRITE & sel_tx)
                 | (PWRITE & sel_tx & (busy | ~en));
    assign wr_ok = xfer & PWRITE & ~err_c;
    assign rd_ok = xfer & ~PWRITE & ~err_c;
    assign rd_rx = rd_ok & sel_rx;
    assign rd_st = rd_ok & sel_st;
    assign abort = wr_ok & sel_ctrl & ~PWDATA[0];

    assign unused_pwdata = ^PWDATA[DW-1:BW];

    // Read mux; both response outputs stay 0 outside completing cycles
    always_comb begin
        rdata_c = '0;
        if (rd_ok & ~PRESET) begin
            if (sel_ctrl) rdata_c = DW'({cs, en});
            if (sel_div)  rdata_c = DW'(clkdiv);
            if (sel_rx)   rdata_c = DW'(rxdata);
            if (sel_st)   rdata_c = DW'({ovr, rxv, busy});
        end
    end

    assign PRDATA  = rdata_c;
    assign PSLVERR = xfer & err_c & ~PRESET;

    // Next-state logic for registers and the SPI sequencer
    always_comb begin
        state_d  = state;
        en_d     = en;
        cs_d     = cs;
        clkdiv_d = clkdiv;
        cnt_d    = cnt;
        shreg_d  = shreg;
        bitcnt_d = bitcnt;
        sclk_d   = sclk;
        mosi_d   = mosi;
        rxdata_d = rxdata;
        rxv_d    = rxv;
        ovr_d    = ovr;

        if (wr_ok & sel_ctrl) begin
            en_d = PWDATA[0];
            cs_d = PWDATA[1];
        end
        if (wr_ok & sel_div) clkdiv_d = PWDATA[BW-1:0];
        if (rd_rx) rxv_d = 1'b0;
        if (rd_st) ovr_d = 1'b0;

        case (state)
            IDLE: begin
                if (wr_ok & sel_tx) begin
                    shreg_d  = PWDATA[BW-1:0];
                    mosi_d   = PWDATA[BW-1];
                    cnt_d    = clkdiv;
                    bitcnt_d = '0;
                    state_d  = LOW;
                end
            end
            LOW: begin
                if (cnt == '0) begin
                    state_d = HIGH;
                    sclk_d  = 1'b1;
                    shreg_d = {shreg[BW-2:0], MISO};
                    cnt_d   = clkdiv;
                end else begin
                    cnt_d = cnt - BW'(1);
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    sclk_d = 1'b0;
                    if (bitcnt == BCW'(BW - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d  = LOW;
                        mosi_d   = shreg[BW-1];
                        bitcnt_d = bitcnt + BCW'(1);
                        cnt_d    = clkdiv;
                    end
                end else begin
                    cnt_d = cnt - BW'(1);
                end
            end
            DONE: begin
                state_d  = IDLE;
                rxdata_d = shreg;
                rxv_d    = 1'b1;
                // a read landing on this same cycle consumed the old byte, so no overrun
                ovr_d    = ovr_d | (rxv & ~rd_rx);
            end
            default: state_d = IDLE;
        endcase

        // Clearing EN cancels any frame in flight without touching received data
        if (abort && busy) begin
            state_d  = IDLE;
            sclk_d   = 1'b0;
            mosi_d   = 1'b0;
            rxdata_d = rxdata;
            rxv_d    = rxv;
            ovr_d    = ovr;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state  <= IDLE;
            en     <= 1'b0;
            cs     <= 1'b0;
            clkdiv <= CLKDIV_RST;
            cnt    <= '0;
            shreg  <= '0;
            bitcnt <= '0;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
            rxdata <= '0;
            rxv    <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            state  <= state_d;
            en     <= en_d;
            cs     <= cs_d;
            clkdiv <= clkdiv_d;
            cnt    <= cnt_d;
            shreg  <= shreg_d;
            bitcnt <= bitcnt_d;
            sclk   <= sclk_d;
            mosi   <= mosi_d;
            rxdata <= rxdata_d;
            rxv    <= rxv_d;
            ovr    <= ovr_d;
        end
    end

    assign SCLK = sclk;
    assign MOSI = mosi;
    assign CS_N = ~cs;

endmodule

// File: tb/tb_apb_spi_master.sv
// Randomized bench for apb_spi_master against a frame-timing model built from cycle arithmetic.
`timescale 1ns/1ps
module tb_apb_spi_master;
    localparam logic [31:0] BASE = 32'h4000_1000;

    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE, PREADY, PSLVERR, SCLK, MOSI, MISO, CS_N;
    logic [31:0] PADDR, PWDATA, PRDATA;

    apb_spi_master #(.CLKDIV_RST(8'd3), .BASE_ADDR(BASE)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA),
        .PSLVERR(PSLVERR), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CS_N(CS_N)
    );

    always #5 PCLK = ~PCLK;

    int unsigned cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;
    bit loopback = 1'b0;

    // Reference model: register contents plus one frame described by start cycle and half length
    bit          m_en, m_cs, m_rxv, m_ovr, m_active, m_coinc;
    logic [7:0]  m_div, m_rxdata, m_tx, m_rx;
    int unsigned m_start, m_h;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic int unsigned m_end();
        return m_start + 16 * m_h;
    endfunction

    task automatic model_reset();
        m_en = 0; m_cs = 0; m_rxv = 0; m_ovr = 0; m_active = 0; m_coinc = 0;
        m_div = 8'd3; m_rxdata = 8'd0; m_tx = 8'd0; m_rx = 8'd0; m_start = 0; m_h = 1;
    endtask

    task automatic settle(input int unsigned n);
        if (m_active && n > m_end()) begin
            m_rxdata = m_rx;
            if (!m_coinc) m_ovr = m_ovr | m_rxv;
            m_rxv    = 1'b1;
            m_active = 1'b0;
        end
    endtask

    task automatic model_access(input logic [31:0] off, input bit write, input logic [31:0] wd,
                                input logic [31:0] got_rd, input logic got_err);
        logic [31:0] exp_rd;
        logic        exp_err;
        bit          bsy;
        int unsigned c;
        c = cyc;
        settle(c);
        bsy = m_active && c <= m_end();
        exp_rd = 32'd0;
        exp_err = 1'b0;
        case (off)
            32'h00: if (write) begin
                        m_en = wd[0]; m_cs = wd[1];
                        if (!m_en && bsy) m_active = 1'b0;
                    end else exp_rd = {30'd0, m_cs, m_en};
            32'h04: if (write) m_div = wd[7:0]; else exp_rd = {24'd0, m_div};
            32'h08: if (!write || bsy || !m_en) exp_err = 1'b1;
                    else begin
                        m_active = 1'b1; m_coinc = 1'b0; m_start = c + 1;
                        m_h = m_div + 1; m_tx = wd[7:0];
                        m_rx = loopback ? wd[7:0] : 8'($urandom);
                    end
            32'h0C: if (write) exp_err = 1'b1;
                    else begin
                        exp_rd = {24'd0, m_rxdata};
                        if (m_active && c == m_end()) m_coinc = 1'b1;
                        m_rxv = 1'b0;
                    end
            32'h10: if (write) exp_err = 1'b1;
                    else begin
                        exp_rd = {29'd0, m_ovr, m_rxv, bsy};
                        m_ovr = 1'b0;
                    end
            default: exp_err = 1'b1;
        endcase
        check("pslverr", got_err, exp_err);
        check("prdata", got_rd, exp_rd);
    endtask

    // Per-cycle comparison of SPI pins and idle bus response
    int unsigned cmp_k;
    logic        cmp_sclk, cmp_mosi, cmp_csn;
    always @(negedge PCLK) begin
        if (chk_on) begin
            cmp_sclk = 1'b0;
            if (m_active && cyc >= m_start && cyc - m_start < 16 * m_h) begin
                cmp_k    = (cyc - m_start) / m_h;
                cmp_sclk = cmp_k[0];
                cmp_mosi = m_tx[7 - cmp_k / 2];
                check("mosi", MOSI, cmp_mosi);
            end
            cmp_csn = ~m_cs;
            check("sclk", SCLK, cmp_sclk);
            check("cs_n", CS_N, cmp_csn);
            if (!(PSEL && PENABLE && PREADY)) begin
                check("prdata_idle", PRDATA, 32'd0);
                check("pslverr_idle", PSLVERR, 32'd0);
            end
        end
    end

    // MISO presents the model's receive byte, one bit per SCLK period
    int unsigned miso_k;
    always @(posedge PCLK) begin
        #2;
        if (m_active && cyc >= m_start && cyc - m_start < 16 * m_h) begin
            miso_k = (cyc - m_start) / m_h;
            MISO = m_rx[7 - miso_k / 2];
        end else begin
            MISO = 1'($urandom);
        end
    end

    // Waveform monitor for the hand-checked frame
    bit         mon_on = 1'b0, mon_csbad = 1'b0;
    int         mon_rises = 0, mon_high = 0;
    logic [7:0] mon_mosi = 8'd0;
    logic       prev_sclk = 1'b0;
    always @(negedge PCLK) begin
        if (mon_on) begin
            if (SCLK && !prev_sclk) begin
                mon_rises++;
                mon_mosi = {mon_mosi[6:0], MOSI};
            end
            if (SCLK) mon_high++;
            if (CS_N) mon_csbad = 1'b1;
        end
        prev_sclk = SCLK;
    end

    task automatic apb(input logic [31:0] off, input bit write, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
        int waits;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PADDR = BASE + off; PWRITE = write; PWDATA = wd; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        waits = 0;
        @(negedge PCLK); #1;
        while (!PREADY && waits < 4) begin
            waits++;
            @(negedge PCLK); #1;
        end
        if (!PREADY) check("pready_timeout", PREADY, 32'd1);
        rd  = PRDATA;
        err = PSLVERR;
        model_access(off, write, wd, rd, err);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_active && cyc <= m_end() + 1 && n < 3000) begin
            @(posedge PCLK); #1;
            n++;
        end
        repeat (2) @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset(input int ncyc);
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(negedge PCLK); #1;
        model_reset();
        repeat (ncyc) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, checks so far %0d", n_checks);
        $fatal(1, "watchdog");
    end

    logic [31:0] rd, wd, off;
    logic        err;
    int          op, gap;

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'd0; PWDATA = 32'd0; MISO = 1'b0;
        model_reset();
        @(posedge PCLK); #1;
        chk_on = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 1'b0;

        // Reset values
        apb(32'h04, 0, 0, rd, err); check("lit_clkdiv_rst", rd, 32'h3); check("lit_clkdiv_err", err, 32'h0);
        apb(32'h10, 0, 0, rd, err); check("lit_status_rst", rd, 32'h0);

        // Loopback frame 0xA5 with CLKDIV=3
        loopback = 1'b1;
        apb(32'h04, 1, 32'h3, rd, err);
        apb(32'h00, 1, 32'h3, rd, err);
        mon_on = 1'b1;
        apb(32'h08, 1, 32'h0000_00A5, rd, err);
        wait_idle();
        mon_on = 1'b0;
        check("lit_rises", mon_rises, 32'd8);
        check("lit_high_cycles", mon_high, 32'd32);
        check("lit_mosi_seq", mon_mosi, 32'hA5);
        check("lit_cs_low", mon_csbad, 32'd0);
        apb(32'h10, 0, 0, rd, err); check("lit_status_rxv", rd, 32'h2);
        apb(32'h0C, 0, 0, rd, err); check("lit_rxdata_a5", rd, 32'hA5);

        // TXDATA while busy is refused, running frame unaffected
        apb(32'h08, 1, 32'h3C, rd, err);
        apb(32'h08, 1, 32'hFF, rd, err); check("lit_tx_busy_err", err, 32'h1);
        wait_idle();
        apb(32'h0C, 0, 0, rd, err); check("lit_rxdata_3c", rd, 32'h3C);

        // Overrun then STATUS read-to-clear
        apb(32'h08, 1, 32'h11, rd, err); wait_idle();
        apb(32'h08, 1, 32'h22, rd, err); wait_idle();
        apb(32'h10, 0, 0, rd, err); check("lit_status_ovr", rd, 32'h6);
        apb(32'h10, 0, 0, rd, err); check("lit_status_reread", rd, 32'h2);
        apb(32'h0C, 0, 0, rd, err); check("lit_rxdata_22", rd, 32'h22);

        // Illegal accesses
        apb(32'h20, 0, 0, rd, err); check("lit_unmapped_rd", err, 32'h1);
        apb(32'h20, 1, 32'hFFFF_FFFF, rd, err); check("lit_unmapped_wr", err, 32'h1);
        apb(32'h10, 1, 32'h7, rd, err); check("lit_status_wr", err, 32'h1);
        apb(32'h10, 0, 0, rd, err); check("lit_status_after_err", rd, 32'h0);
        apb(32'h00, 0, 0, rd, err); check("lit_ctrl_kept", rd, 32'h3);

        // Abort after three SCLK pulses
        apb(32'h08, 1, 32'h5A, rd, err);
        repeat (24) @(posedge PCLK);
        #1;
        apb(32'h00, 1, 32'h2, rd, err);
        apb(32'h10, 0, 0, rd, err); check("lit_status_abort", rd, 32'h0);
        apb(32'h0C, 0, 0, rd, err); check("lit_rxdata_kept", rd, 32'h22);

        // RXDATA read landing on the completion cycle, CLKDIV=1
        apb(32'h00, 1, 32'h3, rd, err);
        apb(32'h04, 1, 32'h1, rd, err);
        apb(32'h08, 1, 32'h81, rd, err); wait_idle();
        apb(32'h08, 1, 32'h7E, rd, err);
        while (cyc + 2 < m_end()) begin
            @(posedge PCLK); #1;
        end
        apb(32'h0C, 0, 0, rd, err);
        apb(32'h10, 0, 0, rd, err);
        apb(32'h0C, 0, 0, rd, err);

        // CLKDIV=0 gives PCLK/2
        apb(32'h04, 1, 32'h0, rd, err);
        apb(32'h08, 1, 32'hC3, rd, err); wait_idle();
        apb(32'h0C, 0, 0, rd, err); check("lit_rxdata_c3", rd, 32'hC3);

        // Reset in the middle of a frame, then normal service
        apb(32'h04, 1, 32'h2, rd, err);
        apb(32'h08, 1, 32'h96, rd, err);
        repeat (10) @(posedge PCLK);
        do_reset(3);
        apb(32'h04, 0, 0, rd, err); check("lit_clkdiv_after_rst", rd, 32'h3);
        apb(32'h10, 0, 0, rd, err); check("lit_status_after_rst", rd, 32'h0);

        // Random traffic with independent receive data
        loopback = 1'b0;
        apb(32'h00, 1, 32'h3, rd, err);
        for (int i = 0; i < 300; i++) begin
            op  = $urandom_range(0, 11);
            gap = $urandom_range(0, 12);
            repeat (gap) @(posedge PCLK);
            wd = $urandom;
            case (op)
                0: begin
                    wd[0] = ($urandom_range(0, 9) != 0);
                    apb(32'h00, 1, wd, rd, err);
                end
                1: if (!(m_active && cyc <= m_end() + 2)) apb(32'h04, 1, 32'($urandom_range(0, 3)), rd, err);
                2, 3, 4: apb(32'h08, 1, wd, rd, err);
                5, 6: apb(32'h0C, 0, 0, rd, err);
                7: apb(32'h10, 0, 0, rd, err);
                8: apb(($urandom_range(0, 1) != 0) ? 32'h04 : 32'h00, 0, 0, rd, err);
                9: apb(32'h08, 0, 0, rd, err);
                10: apb(($urandom_range(0, 1) != 0) ? 32'h10 : 32'h0C, 1, wd, rd, err);
                default: begin
                    case ($urandom_range(0, 3))
                        0: off = 32'h14;
                        1: off = 32'h02;
                        2: off = 32'hFC;
                        default: off = 32'h1000;
                    endcase
                    apb(off, $urandom_range(0, 1) != 0, wd, rd, err);
                end
            endcase
        end
        wait_idle();
        apb(32'h10, 0, 0, rd, err);
        apb(32'h0C, 0, 0, rd, err);
        repeat (4) @(posedge PCLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
